// File: rtl/grid_scan_reader.sv
// grid_scan_reader
// Read-side port for the cell memory grid. A start request freezes the whole
// nr*nc state vector into a snapshot register. The port then streams each cell
// in row-major order over a valid/ready handshake, tagged with its row/column.
// It reports the live-cell population of the scan and pulses done at the end.
//
// Build option: define GRID_SCAN_POPCOUNT_EN to include the population
// counter. When it is undefined, pop_count is tied to zero.
module grid_scan_reader #(
    parameter int nr       = 20,
    parameter int nc       = 20,
    parameter int addr_len = 6,
    parameter int pop_len  = 9
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [nr*nc-1:0]       states,
    output logic                   busy,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [addr_len-1:0]    rd_row,
    output logic [addr_len-1:0]    rd_col,
    output logic                   rd_data,
    output logic                   rd_last,
    output logic                   done,
    output logic [pop_len-1:0]     pop_count
);

    localparam int NCELL = nr * nc;
    localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q;
    logic [NCELL-1:0]      snap_q;
    logic [addr_len-1:0]   row_q;
    logic [addr_len-1:0]   col_q;
    // Flat cell index kept alongside row/col so no multiplier is needed.
    logic [IDX_W-1:0]      idx_q;
    logic                  data_q;
    logic                  last_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [addr_len-1:0]   row_d;
    logic [addr_len-1:0]   col_d;
    logic [IDX_W-1:0]      idx_d;
    logic                  last_d;
    logic                  data_d;

    // Position of the next cell after a transfer, with the data and last flag
    // looked up ahead of time so that the outputs remain pure registers.
    always_comb begin
        row_d = row_q;
        col_d = col_q + addr_len'(1);
        if (col_q == addr_len'(nc - 1)) begin
            col_d = '0;
            row_d = row_q + addr_len'(1);
        end
        idx_d  = idx_q + IDX_W'(1);
        last_d = (row_d == addr_len'(nr - 1)) && (col_d == addr_len'(nc - 1));
        data_d = 1'b0;
        if (!last_q) begin
            data_d = snap_q[idx_d];
        end
    end

    // Scan FSM with registered handshake, address and status outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            snap_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            data_q  <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (start) begin
                        snap_q  <= states;
                        row_q   <= '0;
                        col_q   <= '0;
                        idx_q   <= '0;
                        data_q  <= states[0];
                        last_q  <= (NCELL == 1);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (rd_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            data_q  <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            row_q  <= row_d;
                            col_q  <= col_d;
                            idx_q  <= idx_d;
                            data_q <= data_d;
                            last_q <= last_d;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GRID_SCAN_POPCOUNT_EN
    logic [pop_len-1:0] pop_q;

    // Live-cell count: cleared on an accepted start, bumped on each live transfer.
    always_ff @(posedge clk) begin
        if (clr) begin
            pop_q <= '0;
        end else if (state_q == IDLE && start) begin
            pop_q <= '0;
        end else if (state_q == STREAM && rd_ready && data_q) begin
            pop_q <= pop_q + pop_len'(1);
        end
    end

    assign pop_count = pop_q;
`else
    assign pop_count = '0;
`endif

    assign busy     = busy_q;
    assign rd_valid = valid_q;
    assign rd_row   = row_q;
    assign rd_col   = col_q;
    assign rd_data  = data_q;
    assign rd_last  = last_q;
    assign done     = done_q;

endmodule
